circ_buf_writer: RTL and testbench
==================================

Name: circ_buf_writer

Overview:
- Write-side companion to the read-side data address generator (dag).
- Accepts input samples over a valid/ready handshake and writes them into a circular delay-line buffer in data memory.
- Uses the same base/len/sign/expt configuration model as the read side, so both sides walk an identical buffer.
- Publishes the newest-sample address (head) and a per-sample strobe; the FIR sequencer starts dag reads from head.

Parameters:
AW, 16, data-memory address width
LW, 12, buffer length/offset width (bytes)
DW, 16, sample data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  load configuration this cycle
cfg_base  in  AW  buffer base address
cfg_len  in  LW  buffer length in bytes; 0 = disable
cfg_sign  in  1  0 = advance +stride, 1 = advance -stride
cfg_expt  in  3  stride = 2^expt bytes
in_valid  in  1  sample available
in_data  in  DW  sample value
in_ready  out  1  writer can accept sample
mem_we  out  1  write request to memory arbiter
mem_addr  out  AW  write address
mem_wdata  out  DW  write data
mem_gnt  in  1  arbiter grant; write completes on the clk edge where mem_we and mem_gnt are both high
head  out  AW  address of last completed write
sample_stb  out  1  one-cycle pulse after each completed write
count  out  LW  completed writes since config, saturating (see Optional Feature)
full  out  1  count == len>>expt (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; offset=0; head=0; count=0.
  - All outputs 0: in_ready, mem_we, sample_stb, full, mem_addr, mem_wdata.
- States:
  - IDLE: unconfigured.
  - READY: waiting for a sample.
  - WRITE: holding a sample and requesting memory.
- cfg_we=1 (any state):
  - Latch base/len/sign/expt; offset=0; head=base; count=0.
  - Next state READY, or IDLE if cfg_len==0.
  - Any pending WRITE is aborted: mem_we low next cycle, sample dropped, no sample_stb.
  - cfg_we has priority over every other event.
- in_ready = !cfg_we & ((state==READY) | (state==WRITE & mem_gnt)).
  - The combinational path mem_gnt -> in_ready is intentional; it allows back-to-back writes.
- Handshake accept (in_valid & in_ready): capture in_data into the hold register and go to WRITE.
  - mem_we=1, mem_addr=base+offset and mem_wdata=hold, all registered, from the next cycle.
- WRITE with mem_gnt=0: hold mem_we, mem_addr and mem_wdata stable. in_ready=0.
- WRITE with mem_gnt=1: write completes at that edge. Then:
  - head <= mem_addr.
  - offset advances.
  - sample_stb=1 for the following cycle.
  - count increments.
  - If a new sample is accepted in the same cycle, stay in WRITE with the new data/address; otherwise go to READY.
- Peak throughput: one sample per cycle with continuous grant. Accept-to-mem_we latency: 1 cycle.
- Offset arithmetic is computed LW+1 bits wide, with s=2^expt:
  - sign=0: t=offset+s; offset = (t>=len) ? t-len : t.
  - sign=1: offset = (offset<s) ? offset+len-s : offset-s.
- mem_addr = base + offset, truncated to AW; carry out of AW is discarded.
- len must be a multiple of s; behaviour otherwise is undefined but must not lock up.
- Sequence with len=8, s=2, sign=0: offsets 0,2,4,6,0,... This matches the dag read order.
- in_valid in IDLE is ignored (in_ready=0).

Optional Feature:
- Macro CIRC_BUF_WRITER_FILL_COUNT_EN.
- Defined:
  - count tracks completed writes, saturating at len>>expt.
  - full = (count == len>>expt).
  - Both are cleared by cfg_we and reset.
- Undefined: count and full are tied to 0 and no count register is synthesized.

Test Plan:
- Reset + config: rst_n low mid-WRITE -> mem_we, in_ready, sample_stb drop to 0 immediately; head=0. Then cfg base=AB00 len=8 sign=0 expt=1 -> in_ready=1 next cycle, head=AB00.
- Continuous grant, samples 1..5: writes to AB00, AB02, AB04, AB06, AB00 (wrap) with data 1..5; sample_stb once per write; head ends at AB00; with FILL_COUNT_EN, count=4 and full=1 after the 4th write.
- Decrement: base=1000 len=12 sign=1 expt=2, three samples -> addresses 1000, 1008, 1004; next sample -> 1000.
- Grant stall: mem_gnt low 3 cycles with sample pending at AB02 -> mem_we/mem_addr/mem_wdata stable, in_ready=0; grant -> single write, single sample_stb.
- cfg_we and in_valid in the same cycle as a pending write -> sample not accepted, pending write aborted (no sample_stb), offset=0, next write goes to the new base.
- cfg_len=0 -> state IDLE, in_ready=0; in_valid pulses produce no mem_we.

Source files
------------

// File: rtl/circ_buf_writer_if.sv
// rtl/circ_buf_writer_if.sv - sample-in handshake and memory write-request bus for circ_buf_writer
interface circ_buf_writer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;

  // Writer side: consumes samples, issues memory write requests.
  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt
  );

  // Environment side: sample producer and memory arbiter.
  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt
  );
endinterface

// File: rtl/circ_buf_writer.sv
// rtl/circ_buf_writer.sv - circular delay-line writer; optional fill counter under CIRC_BUF_WRITER_FILL_COUNT_EN
module circ_buf_writer #(
  parameter int AW = 16,
  parameter int LW = 12,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_base,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_sign,
  input  logic [2:0]         cfg_expt,
  circ_buf_writer_if.master  bus,
  output logic [AW-1:0]      head,
  output logic               sample_stb,
  output logic [LW-1:0]      count,
  output logic               full
);

  localparam int LW1 = LW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic          sign_q, sign_d;
  logic [2:0]    expt_q, expt_d;
  logic [LW-1:0] offset_q, offset_d;
  logic [AW-1:0] head_q, head_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          stb_q, stb_d;

  logic          in_ready;
  logic          accept;
  logic          complete;
  logic [LW1-1:0] stride;
  logic [LW1-1:0] off_ext;
  logic [LW1-1:0] len_ext;
  logic [LW1-1:0] t_inc;
  logic [LW-1:0]  off_adv;

  // Next offset along the ring, computed one bit wider so the wrap compare cannot overflow.
  always_comb begin
    stride  = LW1'(1) << expt_q;
    off_ext = {1'b0, offset_q};
    len_ext = {1'b0, len_q};
    t_inc   = off_ext + stride;
    off_adv = offset_q;
    if (!sign_q) begin
      off_adv = (t_inc >= len_ext) ? LW'(t_inc - len_ext) : LW'(t_inc);
    end else begin
      off_adv = (off_ext < stride) ? LW'(off_ext + len_ext - stride) : LW'(off_ext - stride);
    end
  end

  // Handshake qualifiers; grant feeds in_ready directly so a new sample can ride the completing edge.
  always_comb begin
    in_ready = !cfg_we && ((state_q == READY) || ((state_q == WRITE) && bus.mem_gnt));
    accept   = bus.in_valid && in_ready;
    complete = !cfg_we && (state_q == WRITE) && bus.mem_gnt;
  end

  // Next-state and datapath updates; a config load overrides everything, including a pending write.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    sign_d     = sign_q;
    expt_d     = expt_q;
    offset_d   = offset_q;
    head_d     = head_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    hold_d     = hold_q;
    stb_d      = 1'b0;
    if (cfg_we) begin
      base_d   = cfg_base;
      len_d    = cfg_len;
      sign_d   = cfg_sign;
      expt_d   = cfg_expt;
      offset_d = '0;
      head_d   = cfg_base;
      mem_we_d = 1'b0;
      state_d  = (cfg_len == '0) ? IDLE : READY;
    end else begin
      if (complete) begin
        head_d   = mem_addr_q;
        offset_d = off_adv;
        stb_d    = 1'b1;
        mem_we_d = 1'b0;
        state_d  = READY;
      end
      if (accept) begin
        hold_d     = bus.in_data;
        mem_addr_d = base_q + AW'(offset_d);
        mem_we_d   = 1'b1;
        state_d    = WRITE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      sign_q     <= 1'b0;
      expt_q     <= '0;
      offset_q   <= '0;
      head_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      hold_q     <= '0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      sign_q     <= sign_d;
      expt_q     <= expt_d;
      offset_q   <= offset_d;
      head_q     <= head_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      hold_q     <= hold_d;
      stb_q      <= stb_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = hold_q;
  assign head          = head_q;
  assign sample_stb    = stb_q;

`ifdef CIRC_BUF_WRITER_FILL_COUNT_EN
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] limit;

  // Completed-write counter, saturating at the number of slots in the ring.
  always_comb begin
    limit   = len_q >> expt_q;
    count_d = count_q;
    if (cfg_we) begin
      count_d = '0;
    end else if (complete && (count_q != limit)) begin
      count_d = count_q + LW'(1);
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (state_q != IDLE) && (count_q == limit);
`else
  assign count = '0;
  assign full  = 1'b0;
`endif

endmodule

// File: tb/tb_circ_buf_writer.sv
// tb/tb_circ_buf_writer.sv - table-driven self-checking bench for circ_buf_writer
module tb_circ_buf_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [11:0] cfg_len = '0;
  logic        cfg_sign = 1'b0;
  logic [2:0]  cfg_expt = '0;
  logic [15:0] head;
  logic        sample_stb;
  logic [11:0] count;
  logic        full;

  circ_buf_writer_if #(.AW(16), .DW(16)) bus ();

  circ_buf_writer #(.AW(16), .LW(12), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_base   (cfg_base),
    .cfg_len    (cfg_len),
    .cfg_sign   (cfg_sign),
    .cfg_expt   (cfg_expt),
    .bus        (bus),
    .head       (head),
    .sample_stb (sample_stb),
    .count      (count),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cw;
    logic [15:0] base;
    logic [11:0] len;
    logic        sign;
    logic [2:0]  expt;
    logic        v;
    logic [15:0] d;
    logic        g;
    logic        rdy;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] hd;
    logic        stb;
    logic [11:0] cnt;
    logic        fl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic add(input logic cw, input logic [15:0] base, input logic [11:0] len,
                     input logic sign, input logic [2:0] expt, input logic v,
                     input logic [15:0] d, input logic g, input logic rdy, input logic we,
                     input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] hd,
                     input logic stb, input logic [11:0] cnt, input logic fl);
    vec_t r;
    r.cw = cw; r.base = base; r.len = len; r.sign = sign; r.expt = expt;
    r.v = v; r.d = d; r.g = g; r.rdy = rdy; r.we = we; r.addr = addr;
    r.wd = wd; r.hd = hd; r.stb = stb; r.cnt = cnt; r.fl = fl;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mem_gnt  = 1'b0;

    //  cw base    len sg ex  v  d      g   rdy we addr   wd     head   stb cnt fl
    // Increment ring, base AB00, len 8, stride 2, continuous grant, wrap
    add(1, 16'hAB00, 8, 0, 1, 1, 16'h99, 0,  0, 0, 16'h0, 16'h0, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h1, 1,  1, 0, 16'h0,    16'h0, 16'hAB00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h2, 1,  1, 1, 16'hAB00, 16'h1, 16'hAB00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h3, 1,  1, 1, 16'hAB02, 16'h2, 16'hAB00, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h4, 1,  1, 1, 16'hAB04, 16'h3, 16'hAB02, 1, 2, 0);
    add(0, 0, 0, 0, 0, 1, 16'h5, 1,  1, 1, 16'hAB06, 16'h4, 16'hAB04, 1, 3, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0, 1,  1, 1, 16'hAB00, 16'h5, 16'hAB06, 1, 4, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  1, 0, 16'h0,    16'h0, 16'hAB00, 1, 4, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  1, 0, 16'h0,    16'h0, 16'hAB00, 0, 4, 1);
    // Grant stall with sample pending at AB02
    add(0, 0, 0, 0, 0, 1, 16'h77, 0, 1, 0, 16'h0,    16'h0,  16'hAB00, 0, 4, 1);
    add(0, 0, 0, 0, 0, 1, 16'h88, 0, 0, 1, 16'hAB02, 16'h77, 16'hAB00, 0, 4, 1);
    add(0, 0, 0, 0, 0, 1, 16'h88, 0, 0, 1, 16'hAB02, 16'h77, 16'hAB00, 0, 4, 1);
    add(0, 0, 0, 0, 0, 1, 16'h88, 0, 0, 1, 16'hAB02, 16'h77, 16'hAB00, 0, 4, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 1,  1, 1, 16'hAB02, 16'h77, 16'hAB00, 0, 4, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  1, 0, 16'h0,    16'h0,  16'hAB02, 1, 4, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  1, 0, 16'h0,    16'h0,  16'hAB02, 0, 4, 1);
    // Pending write at AB04 aborted by config load with in_valid and grant high
    add(0, 0, 0, 0, 0, 1, 16'h55, 0, 1, 0, 16'h0,    16'h0,  16'hAB02, 0, 4, 1);
    add(1, 16'h1000, 12, 1, 2, 1, 16'h66, 1, 0, 1, 16'hAB04, 16'h55, 16'hAB02, 0, 4, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  1, 0, 16'h0,    16'h0,  16'h1000, 0, 0, 0);
    // Decrement ring, base 1000, len 12, stride 4: 1000, 1008, 1004, 1000
    add(0, 0, 0, 0, 0, 1, 16'hA1, 1, 1, 0, 16'h0,    16'h0,  16'h1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'hA2, 1, 1, 1, 16'h1000, 16'hA1, 16'h1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'hA3, 1, 1, 1, 16'h1008, 16'hA2, 16'h1000, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'hA4, 1, 1, 1, 16'h1004, 16'hA3, 16'h1008, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0, 1,  1, 1, 16'h1000, 16'hA4, 16'h1004, 1, 3, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  1, 0, 16'h0,    16'h0,  16'h1000, 1, 3, 1);
    // Zero length disables the writer
    add(1, 16'h2000, 0, 0, 0, 1, 16'hB1, 1, 0, 0, 16'h0, 16'h0, 16'h1000, 0, 3, 1);
    add(0, 0, 0, 0, 0, 1, 16'hB2, 1, 0, 0, 16'h0,    16'h0,  16'h2000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'hB3, 1, 0, 0, 16'h0,    16'h0,  16'h2000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0,  0, 0, 16'h0,    16'h0,  16'h2000, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_in_ready", 0, 32'(bus.in_ready), 0);
    chk("rst_mem_we", 0, 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 0, 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 0, 32'(bus.mem_wdata), 0);
    chk("rst_head", 0, 32'(head), 0);
    chk("rst_sample_stb", 0, 32'(sample_stb), 0);
    chk("rst_count", 0, 32'(count), 0);
    chk("rst_full", 0, 32'(full), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive at negedge, sample 1 time unit later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cfg_we       = vecs[i].cw;
      cfg_base     = vecs[i].base;
      cfg_len      = vecs[i].len;
      cfg_sign     = vecs[i].sign;
      cfg_expt     = vecs[i].expt;
      bus.in_valid = vecs[i].v;
      bus.in_data  = vecs[i].d;
      bus.mem_gnt  = vecs[i].g;
      #1;
      chk("in_ready", i, 32'(bus.in_ready), 32'(vecs[i].rdy));
      chk("mem_we", i, 32'(bus.mem_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk("mem_addr", i, 32'(bus.mem_addr), 32'(vecs[i].addr));
        chk("mem_wdata", i, 32'(bus.mem_wdata), 32'(vecs[i].wd));
      end
      chk("head", i, 32'(head), 32'(vecs[i].hd));
      chk("sample_stb", i, 32'(sample_stb), 32'(vecs[i].stb));
`ifdef CIRC_BUF_WRITER_FILL_COUNT_EN
      chk("count", i, 32'(count), 32'(vecs[i].cnt));
      chk("full", i, 32'(full), 32'(vecs[i].fl));
`else
      chk("count", i, 32'(count), 0);
      chk("full", i, 32'(full), 0);
`endif
    end

    // Asynchronous reset in the middle of a write burst
    @(negedge clk);
    cfg_we = 1'b1; cfg_base = 16'hAB00; cfg_len = 12'd8; cfg_sign = 1'b0; cfg_expt = 3'd1;
    bus.in_valid = 1'b0; bus.mem_gnt = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h11; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.in_data = 16'h22;
    @(negedge clk);
    bus.in_data = 16'h33;
    #1;
    chk("pre_rst_mem_we", 0, 32'(bus.mem_we), 1);
    chk("pre_rst_stb", 0, 32'(sample_stb), 1);
    chk("pre_rst_in_ready", 0, 32'(bus.in_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", 0, 32'(bus.mem_we), 0);
    chk("arst_in_ready", 0, 32'(bus.in_ready), 0);
    chk("arst_stb", 0, 32'(sample_stb), 0);
    chk("arst_head", 0, 32'(head), 0);
    chk("arst_mem_addr", 0, 32'(bus.mem_addr), 0);
    chk("arst_mem_wdata", 0, 32'(bus.mem_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.mem_gnt = 1'b0;
    cfg_we = 1'b1; cfg_base = 16'hAB00; cfg_len = 12'd8; cfg_sign = 1'b0; cfg_expt = 3'd1;
    #1;
    chk("cfg_in_ready_same", 0, 32'(bus.in_ready), 0);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    chk("cfg_in_ready_next", 0, 32'(bus.in_ready), 1);
    chk("cfg_head", 0, 32'(head), 32'h0000AB00);
    chk("cfg_mem_we", 0, 32'(bus.mem_we), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
